// File: rtl/ysyx_23060201_pkg.sv
// Shared encodings for the write-back unit: result-source selects, FSM states
// and the RV32 load funct3 codes.
package ysyx_23060201_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;

  localparam logic [1:0] WBU_IDLE     = 2'd0;
  localparam logic [1:0] WBU_WAIT_MEM = 2'd1;
  localparam logic [1:0] WBU_COMMIT   = 2'd2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060201_load_ext.sv
// Load alignment and extension: shifts the raw word by the byte offset, then
// sign/zero extends according to funct3. Misaligned accesses are not flagged.
module ysyx_23060201_load_ext
  import ysyx_23060201_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    case (funct3)
      FUNCT3_LB:  data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      FUNCT3_LBU: data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      FUNCT3_LH:  data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      FUNCT3_LHU: data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      FUNCT3_LW:  data = shifted;
      default:    data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_wbu.sv
// Write-back unit: accepts one retiring instruction per handshake, waits for
// load data when needed, and drives the GPR write plus retirement report.
module ysyx_23060201_wbu
  import ysyx_23060201_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [DATA_WIDTH-1:0] in_csr_rdata,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [2:0]            in_ld_funct3,
  input  logic [1:0]            in_ld_off,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rready,
  output logic                  gpr_wen,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic [31:0]           commit_cnt,
  output logic                  pend_valid,
  output logic [ADDR_WIDTH-1:0] pend_rd
);

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] rd_reg;
  logic                  rd_wen_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic [DATA_WIDTH-1:0] accept_result;
  logic [2:0]            funct3_reg;
  logic [1:0]            off_reg;
  logic [31:0]           cnt_reg;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  accept;
  logic                  rd_live;

  // in_ready is gated by reset so that every output reads 0 while held in reset.
  assign in_ready = rst & (state_reg != WBU_WAIT_MEM);
  assign accept   = in_valid & in_ready;

  always_comb begin
    case (in_sel)
      WB_SEL_ALU: accept_result = in_alu_res;
      WB_SEL_PC4: accept_result = in_pc + DATA_WIDTH'(4);
      WB_SEL_CSR: accept_result = in_csr_rdata;
      default:    accept_result = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WBU_IDLE: begin
        if (accept) state_next = (in_sel == WB_SEL_LOAD) ? WBU_WAIT_MEM : WBU_COMMIT;
      end
      WBU_WAIT_MEM: begin
        if (mem_rvalid) state_next = WBU_COMMIT;
      end
      WBU_COMMIT: begin
        if (accept) state_next = (in_sel == WB_SEL_LOAD) ? WBU_WAIT_MEM : WBU_COMMIT;
        else        state_next = WBU_IDLE;
      end
      default: state_next = WBU_IDLE;
    endcase
  end

  ysyx_23060201_load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .rdata (mem_rdata),
    .off   (off_reg),
    .funct3(funct3_reg),
    .data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= WBU_IDLE;
      rd_reg     <= '0;
      rd_wen_reg <= 1'b0;
      pc_reg     <= '0;
      result_reg <= '0;
      funct3_reg <= '0;
      off_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rd_reg     <= in_rd;
        rd_wen_reg <= in_rd_wen;
        pc_reg     <= in_pc;
        result_reg <= accept_result;
        funct3_reg <= in_ld_funct3;
        off_reg    <= in_ld_off;
      end else if (state_reg == WBU_WAIT_MEM && mem_rvalid) begin
        result_reg <= ld_data;
      end
      if (state_reg == WBU_COMMIT) cnt_reg <= cnt_reg + 32'd1;
    end
  end

  // x0 writes are suppressed only at the enable; address and data still follow the capture.
  assign rd_live      = rd_wen_reg & (rd_reg != '0);
  assign mem_rready   = (state_reg == WBU_WAIT_MEM);
  assign commit_valid = (state_reg == WBU_COMMIT);
  assign commit_pc    = pc_reg;
  assign commit_cnt   = cnt_reg;
  assign gpr_wen      = commit_valid & rd_live;
  assign gpr_waddr    = rd_reg;
  assign gpr_wdata    = result_reg;
  assign pend_valid   = rd_live & (state_reg == WBU_WAIT_MEM || state_reg == WBU_COMMIT);
  assign pend_rd      = rd_reg;

endmodule
